// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path: FSM states, ALU select codes,
// opcode/funct constants and datapath mux encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StExecI   = 4'd10,
    StIWb     = 4'd11
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct to ALU select map; funct_valid_o flags the supported subset.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] sel_o,
  output logic       funct_valid_o
);

  always_comb begin
    sel_o         = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  sel_o = ALU_ADD;
      FN_SUB:  sel_o = ALU_SUB;
      FN_AND:  sel_o = ALU_AND;
      FN_OR:   sel_o = ALU_OR;
      FN_NOR:  sel_o = ALU_NOR;
      FN_SLT:  sel_o = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset datapath. Outputs decode the current state;
// pc_write/ir_write are further qualified by mem_ready, zf and reset.
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zf,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] sel,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [3:0] r_sel;
  logic       funct_valid;

  alu_op_decode u_alu_op_decode (
    .funct_i       (funct),
    .sel_o         (r_sel),
    .funct_valid_o (funct_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d    = StFetch;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_REG;
    pc_source  = PC_ALU;
    sel        = ALU_AND;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        sel       = ALU_ADD;
        // The reset gate keeps a ready memory from loading PC/IR while rst_n is held low.
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
        state_d   = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_b = ALUB_IMM_SH2;
        sel       = ALU_ADD;
        case (opcode)
          OP_RTYPE: begin
            state_d = funct_valid ? StExecR : StFetch;
            illegal = ~funct_valid;
          end
          OP_LW, OP_SW:     state_d = StMemAddr;
          OP_BEQ:           state_d = StBranch;
          OP_ADDI, OP_SLTI: state_d = StExecI;
          OP_J:             state_d = StJump;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        sel       = ALU_ADD;
        state_d   = (opcode == OP_LW) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? StFetch : StMemWr;
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_REG;
        sel       = r_sel;
        state_d   = StRWb;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_REG;
        sel       = ALU_SUB;
        pc_source = PC_ALUOUT;
        pc_write  = zf;
        state_d   = StFetch;
      end
      StJump: begin
        pc_source = PC_JUMP;
        pc_write  = 1'b1;
        state_d   = StFetch;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        sel       = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d   = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction table with per-cycle state paths, plus
// hand-written wait-state, reset and mid-store abort sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zf, mem_ready;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] sel, state;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zf         (zf),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .sel        (sel),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [5:0]      op;
    logic [5:0]      fn;
    logic            zf;
    int              ncyc;
    logic [4:0][3:0] path;
    logic [3:0]      sel2;
    logic            pcw2;
    logic [1:0]      pcs2;
    logic            rw_l, dst_l, m2r_l, mw_l, ill1;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0][3:0] pth(input logic [3:0] a, b, c, d, e);
    logic [4:0][3:0] p;
    p[0] = a; p[1] = b; p[2] = c; p[3] = d; p[4] = e;
    return p;
  endfunction

  function automatic vec_t mk(input string name, input logic [5:0] op, fn, input logic z,
                              input int n, input logic [4:0][3:0] p, input logic [3:0] s2,
                              input logic pw2, input logic [1:0] ps2,
                              input logic rw, dst, m2r, mw, ill);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.zf = z; v.ncyc = n; v.path = p; v.sel2 = s2;
    v.pcw2 = pw2; v.pcs2 = ps2; v.rw_l = rw; v.dst_l = dst; v.m2r_l = m2r; v.mw_l = mw;
    v.ill1 = ill;
    return v;
  endfunction

  logic [3:0] lw_path [10];
  int         irw_cnt;

  initial begin
    vecs[0]  = mk("sub",   6'h00, 6'h22, 0, 4, pth(0, 1, 6, 7, 0), 4'b0110, 0, 2'b00, 1, 1, 0, 0, 0);
    vecs[1]  = mk("add",   6'h00, 6'h20, 0, 4, pth(0, 1, 6, 7, 0), 4'b0010, 0, 2'b00, 1, 1, 0, 0, 0);
    vecs[2]  = mk("and",   6'h00, 6'h24, 0, 4, pth(0, 1, 6, 7, 0), 4'b0000, 0, 2'b00, 1, 1, 0, 0, 0);
    vecs[3]  = mk("or",    6'h00, 6'h25, 0, 4, pth(0, 1, 6, 7, 0), 4'b0001, 0, 2'b00, 1, 1, 0, 0, 0);
    vecs[4]  = mk("nor",   6'h00, 6'h27, 0, 4, pth(0, 1, 6, 7, 0), 4'b1100, 0, 2'b00, 1, 1, 0, 0, 0);
    vecs[5]  = mk("slt",   6'h00, 6'h2A, 0, 4, pth(0, 1, 6, 7, 0), 4'b0111, 0, 2'b00, 1, 1, 0, 0, 0);
    vecs[6]  = mk("lw",    6'h23, 6'h00, 0, 5, pth(0, 1, 2, 3, 4), 4'b0010, 0, 2'b00, 1, 0, 1, 0, 0);
    vecs[7]  = mk("sw",    6'h2B, 6'h00, 0, 4, pth(0, 1, 2, 5, 0), 4'b0010, 0, 2'b00, 0, 0, 0, 1, 0);
    vecs[8]  = mk("beq_t", 6'h04, 6'h00, 1, 3, pth(0, 1, 8, 0, 0), 4'b0110, 1, 2'b01, 0, 0, 0, 0, 0);
    vecs[9]  = mk("beq_n", 6'h04, 6'h00, 0, 3, pth(0, 1, 8, 0, 0), 4'b0110, 0, 2'b01, 0, 0, 0, 0, 0);
    vecs[10] = mk("addi",  6'h08, 6'h00, 0, 4, pth(0, 1, 10, 11, 0), 4'b0010, 0, 2'b00, 1, 0, 0, 0, 0);
    vecs[11] = mk("slti",  6'h0A, 6'h00, 0, 4, pth(0, 1, 10, 11, 0), 4'b0111, 0, 2'b00, 1, 0, 0, 0, 0);
    vecs[12] = mk("j",     6'h02, 6'h00, 0, 3, pth(0, 1, 9, 0, 0), 4'b0000, 1, 2'b10, 0, 0, 0, 0, 0);
    vecs[13] = mk("ill_op", 6'h3F, 6'h00, 0, 2, pth(0, 1, 0, 0, 0), 4'b0000, 0, 2'b00, 0, 0, 0, 0, 1);
    vecs[14] = mk("ill_fn", 6'h00, 6'h00, 0, 2, pth(0, 1, 0, 0, 0), 4'b0000, 0, 2'b00, 0, 0, 0, 0, 1);

    lw_path = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};

    // Reset with a ready memory: FETCH outputs, but no PC/IR load.
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; zf = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", state, 4'd0);
    chk("rst_mem_read", mem_read, 1);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_sel", sel, 4'b0010);
    chk("rst_alu_src_b", alu_src_b, 2'b01);
    chk("rst_reg_write", reg_write, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        opcode = vecs[i].op; funct = vecs[i].fn; zf = vecs[i].zf; mem_ready = 1'b1;
        #1;
        chk({vecs[i].name, "_state"}, state, vecs[i].path[c]);
        chk({vecs[i].name, "_illegal"}, illegal, (c == 1) && vecs[i].ill1);
        if (c == 0) begin
          chk({vecs[i].name, "_f_ir_write"}, ir_write, 1);
          chk({vecs[i].name, "_f_pc_write"}, pc_write, 1);
          chk({vecs[i].name, "_f_mem_read"}, mem_read, 1);
        end
        if (c == 2) begin
          chk({vecs[i].name, "_x_sel"}, sel, vecs[i].sel2);
          chk({vecs[i].name, "_x_pc_write"}, pc_write, vecs[i].pcw2);
          chk({vecs[i].name, "_x_pc_source"}, pc_source, vecs[i].pcs2);
        end
        if (c == vecs[i].ncyc - 1) begin
          chk({vecs[i].name, "_l_reg_write"}, reg_write, vecs[i].rw_l);
          chk({vecs[i].name, "_l_reg_dst"}, reg_dst, vecs[i].dst_l);
          chk({vecs[i].name, "_l_mem_to_reg"}, mem_to_reg, vecs[i].m2r_l);
          chk({vecs[i].name, "_l_mem_write"}, mem_write, vecs[i].mw_l);
        end else begin
          chk({vecs[i].name, "_reg_write_idle"}, reg_write, 0);
        end
        @(negedge clk);
      end
    end
    #1;
    chk("table_end_state", state, 4'd0);

    // lw with 2 FETCH and 3 MEM_RD wait cycles: 10 cycles total.
    irw_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      opcode = 6'h23; funct = 6'h00;
      mem_ready = !(c == 0 || c == 1 || c == 5 || c == 6 || c == 7);
      #1;
      chk("lw_wait_state", state, lw_path[c]);
      irw_cnt += int'(ir_write);
      if (!mem_ready) begin
        chk("lw_wait_mem_read", mem_read, 1);
        chk("lw_wait_iord", iord, c >= 5);
        chk("lw_wait_pc_write", pc_write, 0);
      end
      @(negedge clk);
    end
    #1;
    chk("lw_wait_done_state", state, 4'd0);
    chk("lw_wait_ir_pulses", irw_cnt, 1);
    @(negedge clk);

    // sw stalled in MEM_WR, then reset lands mid-cycle.
    opcode = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("sw_stall_state", state, 4'd5);
    chk("sw_stall_mem_write", mem_write, 1);
    @(negedge clk);
    #1;
    chk("sw_stall_hold_state", state, 4'd5);
    chk("sw_stall_hold_iord", iord, 1);
    #1;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("abort_mem_write", mem_write, 0);
    chk("abort_state", state, 4'd0);
    chk("abort_pc_write", pc_write, 0);
    chk("abort_ir_write", ir_write, 0);
    @(negedge clk);
    #1;
    chk("abort_held_state", state, 4'd0);
    chk("abort_held_mem_write", mem_write, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ir_write", ir_write, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
